// File: rtl/dmem_line_buffer_if.sv
// Bundles the memory-stage request/response signals and the line-wide
// Wishbone classic signals of the downstream memory port.
//   dmem_*  : 16-bit request side (address, store data, strobe/cycle, write,
//             byte enables) and 128-bit line response with one-cycle resp.
//   mem_*   : 128-bit downstream bus (cyc/stb/we, line address, write data,
//             byte lanes, read line, ack).
// modport slave  : the line buffer.
// modport master : the agent that issues requests and answers the
//                  downstream bus. In a real system that is two blocks.
interface dmem_line_buffer_if;
  logic [15:0]  dmem_address;
  logic [15:0]  dmem_wdata;
  logic         dmem_action_stb;
  logic         dmem_action_cyc;
  logic         dmem_write;
  logic [1:0]   dmem_byte_enable;
  logic [127:0] dmem_rdata;
  logic         dmem_resp;

  logic [11:0]  mem_address;
  logic         mem_cyc;
  logic         mem_stb;
  logic         mem_we;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_byte_sel;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  modport slave (
    input  dmem_address, dmem_wdata, dmem_action_stb, dmem_action_cyc, dmem_write,
    input  dmem_byte_enable, mem_rdata, mem_ack,
    output dmem_rdata, dmem_resp, mem_address, mem_cyc, mem_stb, mem_we, mem_wdata,
    output mem_byte_sel
  );

  modport master (
    output dmem_address, dmem_wdata, dmem_action_stb, dmem_action_cyc, dmem_write,
    output dmem_byte_enable, mem_rdata, mem_ack,
    input  dmem_rdata, dmem_resp, mem_address, mem_cyc, mem_stb, mem_we, mem_wdata,
    input  mem_byte_sel
  );
endinterface

// File: rtl/dmem_line_buffer.sv
// Data-memory front end: single 128-bit read line buffer, write-through,
// no write allocate. Loads that hit the buffered line answer in one cycle;
// misses fill the line from the downstream Wishbone classic port; stores
// always go downstream and update the buffered line when it holds them.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : dmem_line_buffer_if.slave (request side and downstream bus)
module dmem_line_buffer (
  input logic               clk,
  input logic               rst,
  dmem_line_buffer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StResp} state_e;

  state_e       state_q, state_d;
  logic         valid_q, valid_d;
  logic [11:0]  tag_q, tag_d;
  logic [127:0] line_q, line_d;
  logic [15:0]  req_addr_q, req_addr_d;
  logic [15:0]  req_wdata_q, req_wdata_d;
  logic [1:0]   req_be_q, req_be_d;
  logic         req_we_q, req_we_d;

  logic         req_present;
  logic         hit_in;
  logic         hit_req;
  logic [15:0]  byte_sel;
  logic [127:0] wdata_rep;

  assign req_present = bus.dmem_action_stb & bus.dmem_action_cyc;
  // Hit against the live request (for acceptance) and the latched one (for store merge).
  assign hit_in      = valid_q & (tag_q == bus.dmem_address[15:4]);
  assign hit_req     = valid_q & (tag_q == req_addr_q[15:4]);
  assign byte_sel    = 16'(req_be_q) << {req_addr_q[3:1], 1'b0};
  assign wdata_rep   = {8{req_wdata_q}};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      tag_q       <= '0;
      line_q      <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_we_q    <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      line_q      <= line_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      req_we_q    <= req_we_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_present) begin
          if (bus.dmem_write) begin
            // An empty byte mask completes without touching the bus.
            state_d = (bus.dmem_byte_enable == 2'b00) ? StResp : StWrite;
          end else begin
            state_d = hit_in ? StResp : StFill;
          end
        end
      end
      StFill:  if (bus.mem_ack) state_d = StResp;
      StWrite: if (bus.mem_ack) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    line_d      = line_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    req_we_d    = req_we_q;
    unique case (state_q)
      StIdle: begin
        if (req_present) begin
          req_addr_d  = bus.dmem_address;
          req_wdata_d = bus.dmem_wdata;
          req_be_d    = bus.dmem_byte_enable;
          req_we_d    = bus.dmem_write;
        end
      end
      StFill: begin
        if (bus.mem_ack) begin
          line_d  = bus.mem_rdata;
          tag_d   = req_addr_q[15:4];
          valid_d = 1'b1;
        end
      end
      StWrite: begin
        // Write-through: merge into the buffered line only when it holds the target.
        if (bus.mem_ack && hit_req) begin
          for (int i = 0; i < 16; i++) begin
            if (byte_sel[i]) line_d[i*8 +: 8] = wdata_rep[i*8 +: 8];
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.mem_cyc      = (state_q == StFill) || (state_q == StWrite);
    bus.mem_stb      = (state_q == StFill) || (state_q == StWrite);
    bus.mem_we       = (state_q == StWrite);
    bus.dmem_resp    = (state_q == StResp);
    bus.mem_address  = req_addr_q[15:4];
    bus.mem_byte_sel = byte_sel;
    bus.mem_wdata    = wdata_rep;
    bus.dmem_rdata   = line_q;
  end

endmodule

// File: tb/tb_dmem_line_buffer.sv
module tb_dmem_line_buffer;

  logic clk;
  logic rst;

  dmem_line_buffer_if bus ();

  dmem_line_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [15:0]  addr;
    logic [15:0]  wdata;
    logic         we;
    logic [1:0]   be;
    int           ack_dly;   // cycles after mem_cyc rises before ack
    logic         exp_mem;   // downstream access expected
    logic [15:0]  exp_bs;
    int           exp_lat;   // resp cycle counted from acceptance edge
    logic         chk_rd;
    logic [127:0] exp_rd;
  } vec_t;

  typedef struct {
    string        name;
    logic         chk_rd;
    logic [127:0] exp_rd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  int n_pass;
  int n_total;

  function automatic logic [127:0] pat(input logic [11:0] a);
    return {20'h0, a, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h0123_4567};
  endfunction

  function automatic vec_t mk(input string name, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic we, input logic [1:0] be,
                              input int ack_dly, input logic exp_mem, input logic [15:0] exp_bs,
                              input int exp_lat, input logic chk_rd,
                              input logic [127:0] exp_rd);
    vec_t v;
    v.name = name; v.addr = addr; v.wdata = wdata; v.we = we; v.be = be;
    v.ack_dly = ack_dly; v.exp_mem = exp_mem; v.exp_bs = exp_bs; v.exp_lat = exp_lat;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle_inputs();
    bus.dmem_action_stb  = 1'b0;
    bus.dmem_action_cyc  = 1'b0;
    bus.dmem_address     = 16'hFFFF;
    bus.dmem_wdata       = 16'h0;
    bus.dmem_write       = 1'b0;
    bus.dmem_byte_enable = 2'b00;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t         e;
    logic         got, seen, stable;
    int           lat, first;
    logic [11:0]  a0;
    logic         we0;
    logic [15:0]  bs0;
    logic [127:0] wd0;
    e.name = v.name; e.chk_rd = v.chk_rd; e.exp_rd = v.exp_rd;
    sb.push_back(e);
    @(negedge clk);
    bus.dmem_address     = v.addr;
    bus.dmem_wdata       = v.wdata;
    bus.dmem_write       = v.we;
    bus.dmem_byte_enable = v.be;
    bus.dmem_action_stb  = 1'b1;
    bus.dmem_action_cyc  = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs: the DUT must work from its latched copy.
    idle_inputs();
    bus.dmem_write = ~v.we;
    got = 1'b0; seen = 1'b0; stable = 1'b1; lat = 0; first = 0;
    a0 = '0; we0 = 1'b0; bs0 = '0; wd0 = '0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.dmem_resp) begin
        got = 1'b1;
        lat = c;
        chk({v.name, " cyc_low_at_resp"}, 128'(bus.mem_cyc), 128'(0));
        e = sb.pop_front();
        if (e.chk_rd) chk({e.name, " rdata"}, bus.dmem_rdata, e.exp_rd);
      end else if (bus.mem_cyc) begin
        if (!seen) begin
          seen = 1'b1; first = c;
          a0 = bus.mem_address; we0 = bus.mem_we; bs0 = bus.mem_byte_sel; wd0 = bus.mem_wdata;
        end else if (bus.mem_address !== a0 || bus.mem_we !== we0 ||
                     bus.mem_byte_sel !== bs0 || bus.mem_wdata !== wd0) begin
          stable = 1'b0;
        end
        if (bus.mem_stb !== 1'b1) stable = 1'b0;
        if (c - first == v.ack_dly) begin
          bus.mem_rdata = pat(bus.mem_address);
          bus.mem_ack   = 1'b1;
        end
      end
    end
    bus.mem_ack = 1'b0;
    chk({v.name, " resp_seen"}, 128'(got), 128'(1));
    if (!got && sb.size() > 0) e = sb.pop_front();
    if (got) chk({v.name, " latency"}, 128'(lat), 128'(v.exp_lat));
    chk({v.name, " mem_access"}, 128'(seen), 128'(v.exp_mem));
    if (seen && v.exp_mem) begin
      chk({v.name, " mem_address"}, 128'(a0), 128'(v.addr[15:4]));
      chk({v.name, " mem_we"}, 128'(we0), 128'(v.we));
      chk({v.name, " bus_stable"}, 128'(stable), 128'(1));
      if (v.we) begin
        chk({v.name, " mem_byte_sel"}, 128'(bs0), 128'(v.exp_bs));
        chk({v.name, " mem_wdata"}, wd0, {8{v.wdata}});
      end
    end
  endtask

  logic [127:0] line_w1;
  logic [127:0] line_w2;
  logic [3:0]   resp_bits;
  logic         cyc_any;

  initial begin
    n_pass  = 0;
    n_total = 0;
    idle_inputs();
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    line_w1 = {32'h0000_0123, 32'h89AB_CDEF, 32'hBEEF_BA98, 32'h0123_4567};
    line_w2 = {32'h7700_0123, 32'h89AB_CDEF, 32'hBEEF_BA98, 32'h0123_4567};

    vecs.push_back(mk("rd_miss_1234", 16'h1234, 16'h0,    1'b0, 2'b00, 3, 1'b1, 16'h0,    5, 1'b1, pat(12'h123)));
    vecs.push_back(mk("rd_hit_123A",  16'h123A, 16'h0,    1'b0, 2'b00, 0, 1'b0, 16'h0,    1, 1'b1, pat(12'h123)));
    vecs.push_back(mk("wr_hit_1236",  16'h1236, 16'hBEEF, 1'b1, 2'b11, 1, 1'b1, 16'h00C0, 3, 1'b0, '0));
    vecs.push_back(mk("rd_hit_1236",  16'h1236, 16'h0,    1'b0, 2'b00, 0, 1'b0, 16'h0,    1, 1'b1, line_w1));
    vecs.push_back(mk("wr_miss_5000", 16'h5000, 16'h00A5, 1'b1, 2'b01, 0, 1'b1, 16'h0001, 2, 1'b0, '0));
    vecs.push_back(mk("rd_hit_1230",  16'h1230, 16'h0,    1'b0, 2'b00, 0, 1'b0, 16'h0,    1, 1'b1, line_w1));
    vecs.push_back(mk("wr_be00",      16'h1238, 16'h1111, 1'b1, 2'b00, 0, 1'b0, 16'h0,    1, 1'b0, '0));
    vecs.push_back(mk("wr_hit_123F",  16'h123F, 16'h7700, 1'b1, 2'b10, 2, 1'b1, 16'h8000, 4, 1'b0, '0));
    vecs.push_back(mk("rd_hit_123E",  16'h123E, 16'h0,    1'b0, 2'b00, 0, 1'b0, 16'h0,    1, 1'b1, line_w2));
    vecs.push_back(mk("rd_miss_4560", 16'h4560, 16'h0,    1'b0, 2'b00, 0, 1'b1, 16'h0,    2, 1'b1, pat(12'h456)));
    vecs.push_back(mk("rd_miss_1230", 16'h1230, 16'h0,    1'b0, 2'b00, 1, 1'b1, 16'h0,    3, 1'b1, pat(12'h123)));

    // Reset and reset-state checks
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst dmem_resp",    128'(bus.dmem_resp), 128'(0));
    chk("rst mem_cyc",      128'(bus.mem_cyc), 128'(0));
    chk("rst mem_stb",      128'(bus.mem_stb), 128'(0));
    chk("rst mem_we",       128'(bus.mem_we), 128'(0));
    chk("rst mem_byte_sel", 128'(bus.mem_byte_sel), 128'(0));
    chk("rst mem_wdata",    bus.mem_wdata, 128'(0));
    chk("rst mem_address",  128'(bus.mem_address), 128'(0));
    chk("rst dmem_rdata",   bus.dmem_rdata, 128'(0));
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back hits: request held through resp is taken again.
    @(negedge clk);
    bus.dmem_address    = 16'h1234;
    bus.dmem_write      = 1'b0;
    bus.dmem_action_stb = 1'b1;
    bus.dmem_action_cyc = 1'b1;
    @(posedge clk);
    resp_bits = '0;
    cyc_any   = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      resp_bits[c-1] = bus.dmem_resp;
      cyc_any = cyc_any | bus.mem_cyc;
      if (c == 3) idle_inputs();
    end
    chk("b2b resp_pattern", 128'(resp_bits), 128'(4'b0101));
    chk("b2b no_mem_cyc", 128'(cyc_any), 128'(0));

    // Reset during FILL, then a late ack.
    @(negedge clk);
    bus.dmem_address    = 16'h9990;
    bus.dmem_write      = 1'b0;
    bus.dmem_action_stb = 1'b1;
    bus.dmem_action_cyc = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk("midrst fill_cyc", 128'(bus.mem_cyc), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst cyc_low", 128'(bus.mem_cyc), 128'(0));
    chk("midrst mem_address", 128'(bus.mem_address), 128'(0));
    bus.mem_rdata = pat(12'h999);
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("midrst no_resp_1", 128'(bus.dmem_resp), 128'(0));
    chk("midrst cyc_still_low", 128'(bus.mem_cyc), 128'(0));
    @(negedge clk);
    chk("midrst no_resp_2", 128'(bus.dmem_resp), 128'(0));

    run_vec(mk("rd_after_rst_9990", 16'h9990, 16'h0, 1'b0, 2'b00, 1, 1'b1, 16'h0, 3, 1'b1,
               pat(12'h999)));

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
